mpmc11_rd_collect: RTL and testbench

MPMC11_RD_COLLECT -- requirements
Module: mpmc11_rd_collect

---
 rtl/mpmc11_pkg.sv | 28 ++
 rtl/mpmc11_rd_collect.sv | 94 +++++++++
 tb/tb_mpmc11_rd_collect.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - shared types and constants for the mpmc11 memory controller
// Holds the controller state encoding, the read-collector state encoding and the
// default DRAM read strip width.
package mpmc11_pkg;

  // One DRAM read strip is 32 bytes, matching the 0x20 address step.
  localparam int STRIP_BITS_DEF = 256;

  // Main controller state, driven by the sequencer.
  typedef enum logic [2:0] {
    MS_NOP,
    MS_PRESET1,
    PRESET2,
    MS_ACT,
    MS_READ,
    MS_WRITE,
    MS_PRECHG,
    MS_REFRESH
  } mpmc11_state_t;

  // Read-collector FSM states.
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } mpmc11_col_state_t;

endpackage

// File: rtl/mpmc11_rd_collect.sv
// rtl/mpmc11_rd_collect.sv - gathers DRAM read strips into one line buffer
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   state          : controller state; PRESET2 arms a new burst
//   num_strips     : index of last strip in the burst (clamped to MAX_STRIPS-1)
//   rd_data_valid  : DRAM read strobe, rd_data : one strip of read data
//   strip_cnt      : strips captured so far (drives the address generator)
//   line           : assembled line, strip k at [k*STRIP_BITS +: STRIP_BITS]
//   line_vld       : one-cycle pulse when the line is complete
//   busy           : high while collecting
//   ovf            : sticky, read data arrived while not collecting
module mpmc11_rd_collect
  import mpmc11_pkg::*;
#(
  parameter int STRIP_BITS = STRIP_BITS_DEF,
  parameter int MAX_STRIPS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  mpmc11_state_t                    state,
  input  logic [5:0]                       num_strips,
  input  logic                             rd_data_valid,
  input  logic [STRIP_BITS-1:0]            rd_data,
  output logic [5:0]                       strip_cnt,
  output logic [MAX_STRIPS*STRIP_BITS-1:0] line,
  output logic                             line_vld,
  output logic                             busy,
  output logic                             ovf
);

  localparam logic [5:0] LAST_MAX = 6'(MAX_STRIPS - 1);

  mpmc11_col_state_t                r_fsm;
  logic [5:0]                       r_cnt;
  logic [5:0]                       r_last;
  logic [MAX_STRIPS*STRIP_BITS-1:0] r_line;
  logic                             r_line_vld;
  logic                             r_ovf;
  logic [5:0]                       w_last_clamped;

  // Bursts longer than the buffer are truncated to the buffer size.
  assign w_last_clamped = (num_strips > LAST_MAX) ? LAST_MAX : num_strips;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_line     <= '0;
      r_line_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_line_vld <= 1'b0;
      if (state == PRESET2) begin
        // PRESET2 restarts collection from any state and swallows any
        // strobe in the same cycle; the line buffer keeps its contents.
        r_fsm  <= COLLECT;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_last <= w_last_clamped;
      end else begin
        case (r_fsm)
          COLLECT: begin
            if (rd_data_valid) begin
              // Explicit slot decode: indices >= MAX_STRIPS have no slot.
              for (int k = 0; k < MAX_STRIPS; k++) begin
                if (r_cnt == 6'(k)) r_line[k*STRIP_BITS +: STRIP_BITS] <= rd_data;
              end
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == r_last) begin
                r_fsm      <= DONE;
                r_line_vld <= 1'b1;
              end
            end
          end
          DONE: begin
            r_fsm <= IDLE;
            if (rd_data_valid) r_ovf <= 1'b1;
          end
          default: begin
            if (rd_data_valid) r_ovf <= 1'b1;
          end
        endcase
      end
    end
  end

  assign strip_cnt = r_cnt;
  assign line      = r_line;
  assign line_vld  = r_line_vld;
  assign busy      = (r_fsm == COLLECT);
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mpmc11_rd_collect.sv
// tb/tb_mpmc11_rd_collect.sv - self-checking bench for mpmc11_rd_collect
module tb_mpmc11_rd_collect;
  import mpmc11_pkg::*;

  localparam int SB = 256;
  localparam int MS = 4;

  logic             clk = 1'b0;
  logic             rst;
  mpmc11_state_t    state;
  logic [5:0]       num_strips;
  logic             rd_data_valid;
  logic [SB-1:0]    rd_data;
  logic [5:0]       strip_cnt;
  logic [MS*SB-1:0] line;
  logic             line_vld;
  logic             busy;
  logic             ovf;

  mpmc11_rd_collect #(.STRIP_BITS(SB), .MAX_STRIPS(MS)) dut (
    .clk(clk), .rst(rst), .state(state), .num_strips(num_strips),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .strip_cnt(strip_cnt),
    .line(line), .line_vld(line_vld), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int vld_seen = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [SB-1:0] got, input logic [SB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [SB-1:0] mk(input logic [7:0] b);
    return {32{b}};
  endfunction

  // Behavioural model: a burst is "want" strips long; collecting ends when that
  // many strips have landed, and the completion pulse shows on the next cycle.
  logic          m_coll;
  int            m_want;
  int            m_cnt;
  logic [SB-1:0] m_slot [MS];
  logic          m_vld;
  logic          m_ovf;
  logic          m_nv;

  always @(posedge clk) begin
    if (rst) begin
      m_coll = 1'b0; m_want = 0; m_cnt = 0; m_vld = 1'b0; m_ovf = 1'b0;
      for (int k = 0; k < MS; k++) m_slot[k] = '0;
    end else begin
      m_nv = 1'b0;
      if (state == PRESET2) begin
        m_coll = 1'b1;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_want = ((int'(num_strips) > MS - 1) ? MS - 1 : int'(num_strips)) + 1;
      end else if (m_coll) begin
        if (rd_data_valid) begin
          m_slot[m_cnt] = rd_data;
          m_cnt++;
          if (m_cnt == m_want) begin
            m_coll = 1'b0;
            m_nv   = 1'b1;
          end
        end
      end else if (rd_data_valid) begin
        m_ovf = 1'b1;
      end
      m_vld = m_nv;
    end
  end

  always @(negedge clk) begin
    if (line_vld === 1'b1) vld_seen++;
    if (chk_en) begin
      chk("strip_cnt", SB'(strip_cnt), SB'(m_cnt));
      chk("line_vld", SB'(line_vld), SB'(m_vld));
      chk("busy", SB'(busy), SB'(m_coll));
      chk("ovf", SB'(ovf), SB'(m_ovf));
      for (int k = 0; k < MS; k++)
        chk($sformatf("line_slot%0d", k), line[k*SB +: SB], m_slot[k]);
    end
  end

  task automatic step(input logic p, input logic v, input logic [SB-1:0] d, input logic [5:0] n);
    state         = p ? PRESET2 : MS_NOP;
    num_strips    = n;
    rd_data_valid = v;
    rd_data       = d;
    @(posedge clk);
    #1;
    state         = MS_NOP;
    rd_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 6'd0);
  endtask

  int v0;

  initial begin
    rst = 1'b1; state = MS_NOP; num_strips = '0; rd_data_valid = 1'b0; rd_data = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_strip_cnt", SB'(strip_cnt), SB'(0));
    chk("rst_line0", line[0 +: SB], '0);
    chk("rst_busy", SB'(busy), SB'(0));
    chk("rst_ovf", SB'(ovf), SB'(0));
    chk("rst_line_vld", SB'(line_vld), SB'(0));
    rst = 1'b0;
    idle(1);

    // Four back-to-back strips.
    step(1'b1, 1'b0, '0, 6'd3);
    chk("t1_busy", SB'(busy), SB'(1));
    step(1'b0, 1'b1, mk(8'hA1), 6'd0);
    step(1'b0, 1'b1, mk(8'hB2), 6'd0);
    step(1'b0, 1'b1, mk(8'hC3), 6'd0);
    step(1'b0, 1'b1, mk(8'hD4), 6'd0);
    chk("t1_vld", SB'(line_vld), SB'(1));
    chk("t1_busy_low", SB'(busy), SB'(0));
    chk("t1_cnt", SB'(strip_cnt), SB'(4));
    chk("t1_slot0", line[0 +: SB], mk(8'hA1));
    chk("t1_slot3", line[3*SB +: SB], mk(8'hD4));
    idle(1);
    chk("t1_vld_gone", SB'(line_vld), SB'(0));

    // Single strip.
    step(1'b1, 1'b0, '0, 6'd0);
    step(1'b0, 1'b1, mk(8'h55), 6'd0);
    chk("t2_vld", SB'(line_vld), SB'(1));
    chk("t2_slot0", line[0 +: SB], mk(8'h55));
    chk("t2_slot1", line[1*SB +: SB], mk(8'hB2));
    idle(2);

    // Over-long burst clamps to the buffer size; an extra strobe flags ovf.
    step(1'b1, 1'b0, '0, 6'd9);
    step(1'b0, 1'b1, mk(8'hE5), 6'd0);
    step(1'b0, 1'b1, mk(8'hF6), 6'd0);
    step(1'b0, 1'b1, mk(8'h17), 6'd0);
    step(1'b0, 1'b1, mk(8'h28), 6'd0);
    chk("t3_vld", SB'(line_vld), SB'(1));
    idle(1);
    step(1'b0, 1'b1, mk(8'h39), 6'd0);
    chk("t3_ovf", SB'(ovf), SB'(1));
    chk("t3_slot0", line[0 +: SB], mk(8'hE5));
    idle(1);

    // Abort after two strips, then a full new burst.
    v0 = vld_seen;
    step(1'b1, 1'b0, '0, 6'd3);
    step(1'b0, 1'b1, mk(8'h41), 6'd0);
    step(1'b0, 1'b1, mk(8'h42), 6'd0);
    step(1'b1, 1'b0, '0, 6'd3);
    chk("t4_cnt_restart", SB'(strip_cnt), SB'(0));
    step(1'b0, 1'b1, mk(8'h4A), 6'd0);
    step(1'b0, 1'b1, mk(8'h4B), 6'd0);
    step(1'b0, 1'b1, mk(8'h4C), 6'd0);
    step(1'b0, 1'b1, mk(8'h4D), 6'd0);
    idle(1);
    chk("t4_one_pulse", SB'(vld_seen - v0), SB'(1));
    chk("t4_slot0", line[0 +: SB], mk(8'h4A));

    // Strobes separated by three idle cycles.
    step(1'b1, 1'b0, '0, 6'd3);
    step(1'b0, 1'b1, mk(8'hA1), 6'd0);
    idle(3);
    chk("t5_cnt_hold", SB'(strip_cnt), SB'(1));
    step(1'b0, 1'b1, mk(8'hB2), 6'd0);
    idle(3);
    step(1'b0, 1'b1, mk(8'hC3), 6'd0);
    idle(3);
    step(1'b0, 1'b1, mk(8'hD4), 6'd0);
    chk("t5_vld", SB'(line_vld), SB'(1));
    chk("t5_slot2", line[2*SB +: SB], mk(8'hC3));
    idle(1);

    // ovf set in IDLE, cleared by PRESET2; PRESET2 beats a same-cycle strobe.
    step(1'b0, 1'b1, mk(8'h99), 6'd0);
    chk("t6_ovf", SB'(ovf), SB'(1));
    chk("t6_slot0", line[0 +: SB], mk(8'hA1));
    step(1'b1, 1'b1, mk(8'h77), 6'd1);
    chk("t6_ovf_clr", SB'(ovf), SB'(0));
    chk("t6_cnt", SB'(strip_cnt), SB'(0));

    // Reset mid-burst.
    step(1'b0, 1'b1, mk(8'h66), 6'd0);
    rst = 1'b1;
    step(1'b0, 1'b1, mk(8'h67), 6'd0);
    chk("t7_cnt", SB'(strip_cnt), SB'(0));
    chk("t7_busy", SB'(busy), SB'(0));
    chk("t7_vld", SB'(line_vld), SB'(0));
    chk("t7_slot0", line[0 +: SB], '0);
    rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
